ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the team's 32x8 single-port synchronous RAM. The RAM has one rd_wr select, a 1-cycle registered read and clears on reset. This block sits between two client engines (e.g. a DMA filler and a CPU-side reader) and the RAM. It serialises their accesses, drives the RAM command pins from registers and returns read data with a valid strobe to the owning requester.

Parameters:
DATA_W, 8, RAM data width
ADDR_W, 5, RAM address width (depth 2**ADDR_W = 32)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
req0  input  1  requester 0 access request; held high until gnt0
we0  input  1  requester 0: 1 = write, 0 = read
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
gnt0  output  1  requester 0 grant (combinational, IDLE only)
rvalid0  output  1  requester 0 read data valid, 1-cycle pulse
req1/we1/addr1/wdata1/gnt1/rvalid1  same as requester 0, for requester 1
rdata  output  DATA_W  read data, passthrough of ram_dout; valid only while rvalid0 or rvalid1 is high
ram_rd_wr  output  1  to RAM rd_wr (1 = write)
ram_addr  output  ADDR_W  to RAM addr
ram_din  output  DATA_W  to RAM data_in
ram_dout  input  DATA_W  from RAM data_out

Behaviour:
- Reset (rst low, async): state=IDLE; ram_rd_wr=0, ram_addr=0, ram_din=0; rvalid0=rvalid1=0; gnt0=gnt1=0; last_served=1, so requester 0 wins first. The RAM shares rst and clears its contents too.
- FSM states: IDLE and ACCESS.
- IDLE, no request:
  - command regs load rd_wr=0; addr and din hold.
  - A background read of the held address into the RAM is harmless.
- IDLE, winner selection:
  - Only one requester high: that requester wins.
  - Both high: the one not equal to last_served wins.
- IDLE, a winner exists:
  - gnt<winner>=1 combinationally in that cycle.
  - Next edge: load ram_rd_wr=we, ram_addr=addr, ram_din=wdata from the winner.
  - Next edge: last_served<=winner, pend_rd<=~we, owner<=winner, state<=ACCESS.
- Requester handshake:
  - The requester samples gnt on the same edge and may drop or change req, we, addr and wdata afterwards.
  - req must not be withdrawn before gnt.
- ACCESS (exactly 1 cycle): the RAM executes the command at the edge that ends ACCESS.
  - At that same edge: rvalid<owner><=pend_rd, ram_rd_wr<=0, state<=IDLE.
  - gnt is never asserted in ACCESS.
- Read latency: gnt cycle at edge T. Command is registered at T. The RAM updates data_out at T+1. rvalid is high from T+1 to T+2, and rdata holds the addressed word in that cycle.
- Write completion: the write takes effect at edge T+1 and produces no rvalid. Any later-granted read, from either requester, returns the new data.
- Throughput: at most 1 access per 2 cycles. rvalid for access n overlaps the IDLE/gnt cycle of access n+1, which is allowed.
- Fairness under continuous requests from both: grants alternate 0,1,0,1…, so a requester waits at most 2 accesses.
- rvalid0 and rvalid1 are never high together; gnt0 and gnt1 are never high together.
- Address wrap: none. ADDR_W bits pass straight through, and the full range 0..31 is legal.
- Reset mid-operation: the pending access is dropped, no rvalid is issued, and the next grant goes to requester 0.
- A same-address write by one requester and read by the other is ordered by grant order only; there is no forwarding.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, FSM state encoding (ST_IDLE, ST_ACCESS), and requester-index constants REQ0/REQ1.
- One natural sub-module: rr_arb2. It is purely combinational and takes req0, req1 and last_served to produce a one-hot winner.
- The FSM, command registers and rvalid logic stay in the top module.

Test Plan:
- Reset then idle: all outputs 0 and no gnt for 10 cycles; then a single req0 read of addr 3 → gnt0 in cycle 1, rvalid0 two cycles after gnt, rdata=0x00 (RAM cleared).
- Requester 0 writes 0xA5 to addr 7, then requester 1 reads addr 7 → one gnt0 pulse, then gnt1, then rvalid1 with rdata=0xA5; rvalid0 never asserts.
- req0 and req1 held high for 8 accesses, all reads of addr 0..7 (pre-written with addr+0x10) → grant order 0,1,0,1,0,1,0,1. Each rvalid goes only to its owner with the matching data, and gnt0 and gnt1 are never both high.
- Back-to-back single requester: req1 writes addr 0..31 with 31-i, then reads them all → one access per 2 cycles, and 32 rvalid1 pulses return 31,30,…,0.
- rst driven low in the ACCESS cycle of a req1 read → no rvalid1; after release, simultaneous req0 and req1 → gnt0 first (last_served=1).
- Edge addresses: write 0xFF to addr 31 and 0x01 to addr 0, then read both back → 0xFF and 0x01; addr 31 does not alias addr 0.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared widths, FSM encoding and requester indices
package ram_port_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM-side signal bundle
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  logic              ram_rd_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // Environment side: the two requesters plus the RAM's read port.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_dout,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  ram_rd_wr, ram_addr, ram_din
  );

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_dout,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output ram_rd_wr, ram_addr, ram_din
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - two-way round-robin winner select
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_served,
  output logic [1:0] winner
);

  // One-hot winner; on a tie the requester not served last goes first.
  always_comb begin
    winner = 2'b00;
    if (req0 && req1) begin
      winner = (last_served == REQ0) ? 2'b10 : 2'b01;
    end else if (req0) begin
      winner = 2'b01;
    end else if (req1) begin
      winner = 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter and sequencer for a 32x8 single-port RAM
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);

  state_t            state;
  logic              last_served;
  logic              owner;
  logic              pend_rd;
  logic              rd_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [1:0]        winner;
  logic              idle;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_served (last_served),
    .winner      (winner)
  );

  assign idle = (state == ST_IDLE);

  // Grants only exist in IDLE and are held off while reset is asserted.
  assign bus.gnt0    = rst & idle & winner[0];
  assign bus.gnt1    = rst & idle & winner[1];
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = bus.ram_dout;

  assign bus.ram_rd_wr = rd_wr_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;

  // Command fields of whichever requester wins this cycle.
  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (winner[1]) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // Two-state sequencer: grant and register the command, then let the RAM execute it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      last_served <= REQ1;
      owner       <= REQ0;
      pend_rd     <= 1'b0;
      rd_wr_q     <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rvalid0_q <= 1'b0;
          rvalid1_q <= 1'b0;
          if (|winner) begin
            rd_wr_q     <= sel_we;
            addr_q      <= sel_addr;
            din_q       <= sel_wdata;
            last_served <= winner[1] ? REQ1 : REQ0;
            owner       <= winner[1] ? REQ1 : REQ0;
            pend_rd     <= ~sel_we;
            state       <= ST_ACCESS;
          end else begin
            rd_wr_q <= 1'b0;
          end
        end
        ST_ACCESS: begin
          rvalid0_q <= pend_rd & (owner == REQ0);
          rvalid1_q <= pend_rd & (owner == REQ1);
          rd_wr_q   <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - randomized self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
  } op_t;

  logic clk;
  logic rst;

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 32x8, registered read, write on rd_wr=1, cleared by reset.
  logic [7:0] ram_mem [32];
  logic [7:0] ram_q;
  assign bus.ram_dout = ram_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= 8'h00;
      ram_q <= 8'h00;
    end else if (bus.ram_rd_wr) begin
      ram_mem[bus.ram_addr] <= bus.ram_din;
    end else begin
      ram_q <= ram_mem[bus.ram_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: memory contents by grant order, fairness pointer,
  // in-flight access and the read results due in the next two cycles.
  logic [7:0] ref_mem [32];
  bit         m_busy, m_last, m_own, m_acc_we;
  logic [4:0] m_acc_addr;
  logic [7:0] m_acc_data;
  bit         p1_v, p1_own, p2_v, p2_own;
  logic [7:0] p1_d, p2_d;
  bit         e_g0, e_g1;

  logic [7:0] rlog0 [$];
  logic [7:0] rlog1 [$];
  int         gnt_log [$];

  always @(negedge clk) begin
    if (!rst) begin
      expect_eq("rst_gnt0", bus.gnt0, 0);
      expect_eq("rst_gnt1", bus.gnt1, 0);
      expect_eq("rst_rvalid0", bus.rvalid0, 0);
      expect_eq("rst_rvalid1", bus.rvalid1, 0);
      expect_eq("rst_ram_rd_wr", bus.ram_rd_wr, 0);
      expect_eq("rst_ram_addr", bus.ram_addr, 0);
      expect_eq("rst_ram_din", bus.ram_din, 0);
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
      m_busy = 0;
      m_last = 1;
      p1_v   = 0;
      p2_v   = 0;
    end else begin
      e_g0 = !m_busy && bus.req0 && (!bus.req1 || m_last == 1'b1);
      e_g1 = !m_busy && bus.req1 && (!bus.req0 || m_last == 1'b0);
      expect_eq("gnt0", bus.gnt0, e_g0);
      expect_eq("gnt1", bus.gnt1, e_g1);
      expect_eq("rvalid0", bus.rvalid0, p2_v && !p2_own);
      expect_eq("rvalid1", bus.rvalid1, p2_v && p2_own);
      if (p2_v) expect_eq("rdata", bus.rdata, p2_d);
      if (m_busy) begin
        expect_eq("acc_rd_wr", bus.ram_rd_wr, m_acc_we);
        expect_eq("acc_addr", bus.ram_addr, m_acc_addr);
        expect_eq("acc_din", bus.ram_din, m_acc_data);
      end else begin
        expect_eq("idle_rd_wr", bus.ram_rd_wr, 0);
      end
      if (bus.rvalid0) rlog0.push_back(bus.rdata);
      if (bus.rvalid1) rlog1.push_back(bus.rdata);

      p2_v   = p1_v;
      p2_own = p1_own;
      p2_d   = p1_d;
      p1_v   = 0;
      m_busy = e_g0 || e_g1;
      if (m_busy) begin
        m_own      = e_g1;
        m_last     = e_g1;
        m_acc_we   = e_g1 ? bus.we1 : bus.we0;
        m_acc_addr = e_g1 ? bus.addr1 : bus.addr0;
        m_acc_data = e_g1 ? bus.wdata1 : bus.wdata0;
        if (m_acc_we) begin
          ref_mem[m_acc_addr] = m_acc_data;
        end else begin
          p1_v   = 1;
          p1_own = m_own;
          p1_d   = ref_mem[m_acc_addr];
        end
      end
    end
  end

  op_t q0 [$];
  op_t q1 [$];
  int  n_last;

  function automatic op_t mk(input logic we, input logic [4:0] addr, input logic [7:0] data);
    op_t o;
    o.we   = we;
    o.addr = addr;
    o.data = data;
    return o;
  endfunction

  // Present queued ops, holding each request until granted; optionally insert random idle gaps.
  task automatic run_ops(input int budget, input bit rnd_idle);
    int n;
    bit p0, p1, g0, g1;
    n  = 0;
    p0 = 0;
    p1 = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      if (!p0 && q0.size() != 0) p0 = rnd_idle ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!p1 && q1.size() != 0) p1 = rnd_idle ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.req0 = p0;
      bus.req1 = p1;
      if (p0) begin
        bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].data;
      end else begin
        bus.we0 = 1'($urandom); bus.addr0 = 5'($urandom); bus.wdata0 = 8'($urandom);
      end
      if (p1) begin
        bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].data;
      end else begin
        bus.we1 = 1'($urandom); bus.addr1 = 5'($urandom); bus.wdata1 = 8'($urandom);
      end
      @(negedge clk);
      g0 = bus.gnt0;
      g1 = bus.gnt1;
      if (g0) gnt_log.push_back(0);
      if (g1) gnt_log.push_back(1);
      @(posedge clk);
      #1;
      if (g0 && q0.size() != 0) begin void'(q0.pop_front()); p0 = 0; end
      if (g1 && q1.size() != 0) begin void'(q1.pop_front()); p1 = 0; end
      n++;
    end
    bus.req0 = 0;
    bus.req1 = 0;
    expect_eq("run_drained", (q0.size() == 0 && q1.size() == 0), 1);
    n_last = n;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst = 0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;

    // Idle after reset, then a single read of a cleared location.
    repeat (10) @(posedge clk);
    #1;
    rlog0.delete();
    q0.push_back(mk(0, 5'd3, 8'h00));
    run_ops(20, 0);
    expect_eq("p1_n_rvalid0", rlog0.size(), 1);
    if (rlog0.size() == 1) expect_eq("p1_rdata", rlog0[0], 8'h00);

    // Requester 0 writes, requester 1 reads it back.
    rlog0.delete();
    rlog1.delete();
    gnt_log.delete();
    q0.push_back(mk(1, 5'd7, 8'hA5));
    run_ops(20, 0);
    q1.push_back(mk(0, 5'd7, 8'h00));
    run_ops(20, 0);
    expect_eq("p2_n_gnt", gnt_log.size(), 2);
    expect_eq("p2_n_rvalid0", rlog0.size(), 0);
    expect_eq("p2_n_rvalid1", rlog1.size(), 1);
    if (rlog1.size() == 1) expect_eq("p2_rdata", rlog1[0], 8'hA5);

    // Fairness: both requesters continuously busy.
    for (int i = 0; i < 8; i++) q1.push_back(mk(1, 5'(i), 8'(i + 8'h10)));
    run_ops(60, 0);
    gnt_log.delete();
    rlog0.delete();
    rlog1.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, 5'(2 * i), 8'h00));
      q1.push_back(mk(0, 5'(2 * i + 1), 8'h00));
    end
    run_ops(60, 0);
    expect_eq("p3_n_gnt", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) expect_eq("p3_gnt_order", gnt_log[i], i % 2);
    for (int i = 0; i < 4 && i < rlog0.size(); i++) expect_eq("p3_rdata0", rlog0[i], 8'(2 * i + 8'h10));
    for (int i = 0; i < 4 && i < rlog1.size(); i++) expect_eq("p3_rdata1", rlog1[i], 8'(2 * i + 8'h11));

    // Back-to-back single requester over the full address range.
    rlog1.delete();
    for (int i = 0; i < 32; i++) q1.push_back(mk(1, 5'(i), 8'(31 - i)));
    for (int i = 0; i < 32; i++) q1.push_back(mk(0, 5'(i), 8'h00));
    run_ops(400, 0);
    expect_eq("p4_cycles", n_last, 127);
    expect_eq("p4_n_rvalid1", rlog1.size(), 32);
    for (int i = 0; i < 32 && i < rlog1.size(); i++) expect_eq("p4_rdata", rlog1[i], 8'(31 - i));

    // Reset during the ACCESS cycle of a requester 1 read.
    rlog1.delete();
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5'd4;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.gnt1 && k < 10);
    expect_eq("p5_gnt1_seen", bus.gnt1, 1);
    @(posedge clk);
    #1;
    bus.req1 = 0;
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    repeat (4) @(posedge clk);
    #1;
    expect_eq("p5_no_rvalid1", rlog1.size(), 0);
    gnt_log.delete();
    q0.push_back(mk(0, 5'd9, 8'h00));
    q1.push_back(mk(0, 5'd9, 8'h00));
    run_ops(20, 0);
    expect_eq("p5_n_gnt", gnt_log.size(), 2);
    if (gnt_log.size() != 0) expect_eq("p5_first_gnt", gnt_log[0], 0);

    // Edge addresses must not alias.
    rlog0.delete();
    q0.push_back(mk(1, 5'd31, 8'hFF));
    q0.push_back(mk(1, 5'd0, 8'h01));
    q0.push_back(mk(0, 5'd31, 8'h00));
    q0.push_back(mk(0, 5'd0, 8'h00));
    run_ops(40, 0);
    expect_eq("p6_n_rvalid0", rlog0.size(), 2);
    if (rlog0.size() == 2) begin
      expect_eq("p6_addr31", rlog0[0], 8'hFF);
      expect_eq("p6_addr0", rlog0[1], 8'h01);
    end

    // Random mixed traffic from both requesters with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      q0.push_back(mk(1'($urandom), 5'($urandom), 8'($urandom)));
      q1.push_back(mk(1'($urandom), 5'($urandom), 8'($urandom)));
    end
    run_ops(2000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
